// File: rtl/boot_run_ctrl_if.sv
// Host-to-controller program-word stream: one 32-bit word per valid/ready handshake.
interface boot_run_ctrl_if;
  logic        valid;
  logic [31:0] data;
  logic        ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/boot_run_ctrl.sv
// Boot/run sequencer for the miniRV core: clears state, streams a program into RAM,
// releases the core and halts it on EBREAK or when the run-cycle budget runs out.
module boot_run_ctrl #(
  parameter logic [31:0] LOAD_BASE   = 32'h0000_0000,
  parameter int unsigned MAX_CYCLES  = 1000000,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       prog_len,
  boot_run_ctrl_if.slave    load,
  input  logic [31:0]       cpu_pc,
  input  logic [31:0]       cpu_inst,
  output logic              cpu_en,
  output logic              reg_reset,
  output logic              mem_reset,
  output logic              rom_wen,
  output logic [31:0]       rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count,
  output logic [31:0]       halt_pc
);

  localparam logic [31:0] BUDGET_LAST = 32'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;

  state_t      state_r, state_s;
  logic [31:0] idx_r, len_r, count_r, halt_pc_r;
  logic        timeout_r;
  logic        start_ok_s, hs_s, last_s, ebreak_s, budget_s, ready_s;

  // Next-state decode and handshake qualifiers
  always_comb begin
    state_s    = state_r;
    start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
    hs_s       = (state_r == LOAD) && load.valid;
    last_s     = (idx_r == (len_r - 32'd1));
    ebreak_s   = (cpu_inst == EBREAK_INST);
    budget_s   = (count_r == BUDGET_LAST);
    case (state_r)
      IDLE:    if (start_ok_s) state_s = CLEAR; else state_s = IDLE;
      CLEAR:   if (len_r != 32'd0) state_s = LOAD; else state_s = RUN;
      LOAD:    if (hs_s && last_s) state_s = RUN; else state_s = LOAD;
      RUN:     if (ebreak_s || budget_s) state_s = DONE; else state_s = RUN;
      DONE:    if (start_ok_s) state_s = CLEAR; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register, word index, run counter and halt capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= 32'd0;
      len_r     <= 32'd0;
      count_r   <= 32'd0;
      halt_pc_r <= 32'd0;
      timeout_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_ok_s) begin
        len_r     <= prog_len;
        idx_r     <= 32'd0;
        count_r   <= 32'd0;
        halt_pc_r <= 32'd0;
        timeout_r <= 1'b0;
      end else if (hs_s) begin
        idx_r <= idx_r + 32'd1;
      end else if (state_r == RUN) begin
        if (count_r != 32'hFFFF_FFFF) count_r <= count_r + 32'd1;
        // EBREAK takes priority when it lands on the last budgeted cycle
        if (ebreak_s) begin
          halt_pc_r <= cpu_pc;
          timeout_r <= 1'b0;
        end else if (budget_s) begin
          halt_pc_r <= cpu_pc;
          timeout_r <= 1'b1;
        end
      end
    end
  end

  // Per-state core control; reset forces the idle values in the same cycle
  always_comb begin
    reg_reset = 1'b1;
    mem_reset = 1'b0;
    cpu_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    ready_s   = 1'b0;
    rom_wen   = 1'b0;
    rom_addr  = 32'd0;
    rom_wdata = 32'd0;
    if (reset) begin
      reg_reset = 1'b1;
    end else begin
      case (state_r)
        IDLE: reg_reset = 1'b1;
        CLEAR: begin
          mem_reset = 1'b1;
          busy      = 1'b1;
        end
        LOAD: begin
          busy    = 1'b1;
          ready_s = 1'b1;
          if (load.valid) begin
            rom_wen   = 1'b1;
            rom_wdata = load.data;
            rom_addr  = LOAD_BASE + (idx_r << 2);
          end else begin
            rom_wen = 1'b0;
          end
        end
        RUN: begin
          reg_reset = 1'b0;
          cpu_en    = 1'b1;
          busy      = 1'b1;
        end
        DONE: begin
          reg_reset = 1'b0;
          done      = 1'b1;
          timeout   = timeout_r;
        end
        default: reg_reset = 1'b1;
      endcase
    end
  end

  assign load.ready  = ready_s;
  assign cycle_count = count_r;
  assign halt_pc     = halt_pc_r;

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Directed bench for boot_run_ctrl with a tiny core/RAM model (addi only) behind it.
module tb_boot_run_ctrl;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] prog_len, cpu_pc, cpu_inst, rom_addr, rom_wdata, cycle_count, halt_pc;
  logic        cpu_en, reg_reset, mem_reset, rom_wen, busy, done, timeout;

  boot_run_ctrl_if lif ();

  boot_run_ctrl #(.MAX_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .load(lif),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_en(cpu_en), .reg_reset(reg_reset),
    .mem_reset(mem_reset), .rom_wen(rom_wen), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count), .halt_pc(halt_pc)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI1  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] ADDI2  = 32'h0070_8113; // addi x2,x1,7
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // Core model: fetch from a 16-word RAM, execute addi when enabled
  logic [31:0] mem  [0:15];
  logic [31:0] regs [0:3];
  logic [31:0] pc_m;
  assign cpu_pc   = pc_m;
  assign cpu_inst = mem[pc_m[5:2]];

  always @(posedge clk) begin
    if (mem_reset) for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    else if (rom_wen) mem[rom_addr[5:2]] <= rom_wdata;
    if (reg_reset) begin
      pc_m <= 32'd0;
      for (int i = 0; i < 4; i++) regs[i] <= 32'd0;
    end else if (cpu_en) begin
      pc_m <= pc_m + 32'd4;
      if (cpu_inst[6:0] == 7'h13 && cpu_inst[14:12] == 3'd0 && cpu_inst[11:7] != 5'd0)
        regs[cpu_inst[8:7]] <= regs[cpu_inst[16:15]] + {{20{cpu_inst[31]}}, cpu_inst[31:20]};
    end
  end

  // Write log of every RAM write the controller issues
  logic [31:0] addr_log [0:63];
  logic [31:0] data_log [0:63];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (rom_wen) begin
      addr_log[wr_cnt] <= rom_addr;
      data_log[wr_cnt] <= rom_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prog [0:7];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] len);
    start = 1'b1;
    prog_len = len;
    cyc();
    start = 1'b0;
  endtask

  // Stream n words from prog[]; pat bit c gives valid in cycle c (1 beyond bit 7)
  task automatic load_seq(input int n, input logic [7:0] pat);
    int k = 0;
    logic v, rdy;
    for (int c = 0; c < 32 && k < n; c++) begin
      v = (c < 8) ? pat[c] : 1'b1;
      lif.valid = v;
      lif.data  = prog[k];
      #1;
      rdy = lif.ready;
      check_eq("ld_ready", {31'd0, rdy}, 32'd1);
      check_eq("ld_wen", {31'd0, rom_wen}, {31'd0, v});
      if (v) check_eq("ld_addr", rom_addr, 32'(k * 4));
      @(posedge clk);
      if (v && rdy) k++;
      #1;
    end
    lif.valid = 1'b0;
    check_eq("ld_words", 32'(k), 32'(n));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 50 && !done; i++) cyc();
    check_eq(tag, {31'd0, done}, 32'd1);
  endtask

  int base;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; prog_len = 32'd0; lif.valid = 1'b0; lif.data = 32'd0;
    cyc(); cyc();
    check_eq("rst_reg_reset", {31'd0, reg_reset}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_count", cycle_count, 32'd0);
    check_eq("rst_halt_pc", halt_pc, 32'd0);
    reset = 1'b0;
    cyc();

    // Load addi/addi/ebreak with valid held high, then run to EBREAK
    prog[0] = ADDI1; prog[1] = ADDI2; prog[2] = EBREAK;
    base = wr_cnt;
    do_start(32'd3);
    check_eq("clr_mem_reset", {31'd0, mem_reset}, 32'd1);
    check_eq("clr_busy", {31'd0, busy}, 32'd1);
    cyc();
    load_seq(3, 8'hFF);
    check_eq("t1_run_cpu_en", {31'd0, cpu_en}, 32'd1);
    check_eq("t1_run_ready", {31'd0, lif.ready}, 32'd0);
    check_eq("t1_wr_cnt", 32'(wr_cnt - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq("t1_addr_log", addr_log[base + i], 32'(i * 4));
      check_eq("t1_data_log", data_log[base + i], prog[i]);
    end
    wait_done("t1_done");
    check_eq("t1_timeout", {31'd0, timeout}, 32'd0);
    check_eq("t1_count", cycle_count, 32'd3);
    check_eq("t1_halt_pc", halt_pc, 32'd8);
    for (int i = 0; i < 10; i++) cyc();
    check_eq("t1_x1", regs[1], 32'd5);
    check_eq("t1_x2", regs[2], 32'd12);
    check_eq("t1_done_held", {31'd0, done}, 32'd1);
    check_eq("t1_cpu_en_off", {31'd0, cpu_en}, 32'd0);
    check_eq("t1_count_held", cycle_count, 32'd3);

    // Start from DONE with prog_len=0: single CLEAR cycle, straight to RUN, no writes
    base = wr_cnt;
    do_start(32'd0);
    check_eq("t2_done_clr", {31'd0, done}, 32'd0);
    check_eq("t2_count_clr", cycle_count, 32'd0);
    check_eq("t2_mem_reset", {31'd0, mem_reset}, 32'd1);
    cyc();
    check_eq("t2_mem_reset_1cyc", {31'd0, mem_reset}, 32'd0);
    check_eq("t2_run", {31'd0, cpu_en}, 32'd1);
    start = 1'b1; cyc(); start = 1'b0;
    check_eq("t2_start_in_run", {31'd0, cpu_en & busy & ~mem_reset}, 32'd1);
    wait_done("t2_done");
    check_eq("t2_timeout", {31'd0, timeout}, 32'd1);
    check_eq("t2_count", cycle_count, 32'd4);
    check_eq("t2_halt_pc", halt_pc, 32'd12);
    check_eq("t2_no_wen", 32'(wr_cnt - base), 32'd0);

    // Gapped valid 1,0,0,1,1 for three nops; budget expiry ends the run
    prog[0] = NOP; prog[1] = NOP; prog[2] = NOP;
    base = wr_cnt;
    do_start(32'd3);
    cyc();
    load_seq(3, 8'b1111_1001);
    check_eq("t3_wr_cnt", 32'(wr_cnt - base), 32'd3);
    for (int i = 0; i < 3; i++) check_eq("t3_addr_log", addr_log[base + i], 32'(i * 4));
    wait_done("t3_done");
    check_eq("t3_timeout", {31'd0, timeout}, 32'd1);
    check_eq("t3_count", cycle_count, 32'd4);

    // EBREAK on the last budgeted cycle wins over the timeout
    prog[3] = EBREAK;
    do_start(32'd4);
    cyc();
    load_seq(4, 8'hFF);
    wait_done("t4_done");
    check_eq("t4_timeout", {31'd0, timeout}, 32'd0);
    check_eq("t4_count", cycle_count, 32'd4);
    check_eq("t4_halt_pc", halt_pc, 32'd12);

    // Reset after the first word of a load, then reload a one-word program
    do_start(32'd3);
    cyc();
    lif.valid = 1'b1; lif.data = NOP;
    cyc();
    reset = 1'b1;
    #1;
    check_eq("t5_rst_wen", {31'd0, rom_wen}, 32'd0);
    cyc();
    reset = 1'b0; lif.valid = 1'b0;
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_reg_reset", {31'd0, reg_reset}, 32'd1);
    prog[0] = EBREAK;
    base = wr_cnt;
    do_start(32'd1);
    cyc();
    load_seq(1, 8'hFF);
    check_eq("t5_wr_cnt", 32'(wr_cnt - base), 32'd1);
    check_eq("t5_addr", addr_log[base], 32'd0);
    wait_done("t5_done");
    check_eq("t5_count", cycle_count, 32'd1);
    check_eq("t5_halt_pc", halt_pc, 32'd0);
    check_eq("t5_timeout", {31'd0, timeout}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
